// File: rtl/state_scheduler_pkg.sv
// Shared definitions for the state scheduler and config_controller:
// state codes, FSM encoding and the queued request record.
package state_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL      = 3'd0,
        ST_ANESTHESIA  = 3'd1,
        ST_PSYCHEDELIC = 3'd2,
        ST_FLOW        = 3'd3,
        ST_MEDITATION  = 3'd4
    } state_code_e;

    localparam logic [2:0] ST_LAST_VALID = ST_MEDITATION;

    typedef enum logic [1:0] {
        FSM_IDLE       = 2'd0,
        FSM_WAIT_START = 2'd1,
        FSM_WAIT_DONE  = 2'd2,
        FSM_DWELL      = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic [2:0]  state;
        logic [15:0] duration;
    } sched_req_t;

    localparam int REQ_W = $bits(sched_req_t);

    // Codes 5..7 are outside the defined state set.
    function automatic logic is_valid_state(input logic [2:0] s);
        return s <= ST_LAST_VALID;
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// Request queue: power-of-two depth, registered occupancy count,
// single-cycle flush that overrides push and pop.
module sched_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 19,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !i_flush && !o_full;
    assign w_pop   = i_pop  && !i_flush && !o_empty;

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally at the power-of-two depth; flush rewinds both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/state_scheduler.sv
// Queues state requests and issues them one at a time to
// config_controller, waiting for its transition and then holding the
// settled state for a minimum dwell before taking the next request.
module state_scheduler
    import state_scheduler_pkg::*;
#(
    parameter  int          FIFO_DEPTH    = 4,
    parameter  logic [15:0] MIN_DWELL     = 16'd4000,
    parameter  int          START_TIMEOUT = 8,
    localparam int          CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_state,
    input  logic [15:0]   req_duration,
    input  logic          flush,
    input  logic          transitioning,
    output logic [2:0]    state_select,
    output logic [15:0]   transition_duration,
    output logic          busy,
    output logic [CW-1:0] queue_count,
    output logic          err_invalid,
    output logic          err_timeout
);

    localparam logic [15:0] TO_INIT = 16'(START_TIMEOUT);

    fsm_state_e  r_state, w_next;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_sel;
    logic [15:0] r_dur;
    logic        r_err_inv, r_err_to;
    logic        r_flush_pend;
    logic        r_rdy_en;
    logic        w_load_sel, w_set_to;
    logic        w_accept, w_enq, w_pop;
    logic        w_empty, w_full;
    logic [CW-1:0] w_count;
    sched_req_t  w_head, w_in;

    // Readiness comes from the registered count only, and is held low
    // until the first clock after reset release.
    assign req_ready = r_rdy_en && (w_count < CW'(FIFO_DEPTH)) && !flush;
    assign w_accept  = req_valid && req_ready;
    assign w_enq     = w_accept && is_valid_state(req_state);
    assign w_pop     = clk_en && (r_state == FSM_IDLE) && !w_empty && !flush;
    assign w_in      = '{state: req_state, duration: req_duration};

    sched_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_enq),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign state_select        = r_sel;
    assign transition_duration = r_dur;
    assign busy                = (r_state != FSM_IDLE);
    assign queue_count         = w_count;
    assign err_invalid         = r_err_inv;
    assign err_timeout         = r_err_to;

    // Next state: one shared down-counter serves as start timeout and dwell.
    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_cnt;
        w_load_sel = 1'b0;
        w_set_to   = 1'b0;
        if (clk_en) begin
            case (r_state)
                FSM_IDLE: begin
                    // A request for the state already selected is dropped.
                    if (w_pop && (w_head.state != r_sel)) begin
                        w_load_sel = 1'b1;
                        w_cnt_nxt  = TO_INIT;
                        w_next     = FSM_WAIT_START;
                    end
                end
                FSM_WAIT_START: begin
                    if (transitioning) begin
                        w_next = FSM_WAIT_DONE;
                    end else if (r_cnt <= 16'd1) begin
                        w_set_to  = 1'b1;
                        w_cnt_nxt = MIN_DWELL;
                        w_next    = FSM_DWELL;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                FSM_WAIT_DONE: begin
                    if (!transitioning) begin
                        w_cnt_nxt = MIN_DWELL;
                        w_next    = FSM_DWELL;
                    end
                end
                FSM_DWELL: begin
                    // A dwell of 0 or 1 both end on the first tick.
                    if (flush || r_flush_pend || (r_cnt <= 16'd1)) begin
                        w_next = FSM_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                default: w_next = FSM_IDLE;
            endcase
        end
    end

    // State, counter, selected outputs and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FSM_IDLE;
            r_cnt        <= '0;
            r_sel        <= ST_NORMAL;
            r_dur        <= '0;
            r_err_inv    <= 1'b0;
            r_err_to     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_rdy_en     <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nxt;
            r_rdy_en <= 1'b1;
            if (w_load_sel) begin
                r_sel <= w_head.state;
                r_dur <= w_head.duration;
            end
            if (w_accept && !is_valid_state(req_state)) r_err_inv <= 1'b1;
            if (w_set_to) r_err_to <= 1'b1;
            // A flush seen during dwell cuts it short at the next tick.
            r_flush_pend <= (w_next == FSM_DWELL) &&
                            (r_flush_pend || (flush && r_state == FSM_DWELL));
        end
    end

endmodule

// File: tb/tb_state_scheduler.sv
// Randomised bench for state_scheduler against a queue-based reference
// model that tracks phase and elapsed ticks.
module tb_state_scheduler;

    localparam int          DEPTH = 4;
    localparam logic [15:0] DWELL = 16'd12;
    localparam int          TOUT  = 8;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam int          NCYC  = 8000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_state = '0;
    logic [15:0]   req_duration = '0;
    logic          flush = 1'b0;
    logic          transitioning = 1'b0;
    logic [2:0]    state_select;
    logic [15:0]   transition_duration;
    logic          busy;
    logic [CW-1:0] queue_count;
    logic          err_invalid;
    logic          err_timeout;

    state_scheduler #(.FIFO_DEPTH(DEPTH), .MIN_DWELL(DWELL), .START_TIMEOUT(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_duration(req_duration),
        .flush(flush), .transitioning(transitioning),
        .state_select(state_select), .transition_duration(transition_duration),
        .busy(busy), .queue_count(queue_count),
        .err_invalid(err_invalid), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: pending requests as a queue, plus which phase the
    // scheduler is in and how many ticks that phase has consumed.
    typedef struct { int st; int dur; } ent_t;
    ent_t m_q[$];
    int   ph;            // 0 idle, 1 awaiting start, 2 awaiting done, 3 settled
    int   ticks;
    int   m_sel, m_dur;
    bit   m_inv, m_to, m_cut, m_live;
    bit   no_resp;

    function automatic bit m_ready();
        return m_live && (m_q.size() < DEPTH) && !flush;
    endfunction

    function automatic int hold_ticks(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    task automatic m_reset();
        m_q.delete();
        ph = 0; ticks = 0; m_sel = 0; m_dur = 0;
        m_inv = 0; m_to = 0; m_cut = 0; m_live = 0;
    endtask

    task automatic m_step();
        bit rdy;
        int old;
        ent_t h;
        rdy = m_ready();
        old = ph;
        if (clk_en) begin
            if (ph == 0) begin
                if (!flush && m_q.size() > 0) begin
                    h = m_q.pop_front();
                    if (h.st != m_sel) begin
                        m_sel = h.st; m_dur = h.dur; ph = 1; ticks = 0;
                    end
                end
            end else if (ph == 1) begin
                if (transitioning) ph = 2;
                else begin
                    ticks++;
                    if (ticks >= hold_ticks(TOUT)) begin
                        m_to = 1; ph = 3; ticks = 0;
                    end
                end
            end else if (ph == 2) begin
                if (!transitioning) begin ph = 3; ticks = 0; end
            end else begin
                ticks++;
                if (flush || m_cut || ticks >= hold_ticks(int'(DWELL))) ph = 0;
            end
        end
        m_cut = (ph == 3) && (m_cut || (flush && old == 3));
        if (flush) m_q.delete();
        else if (req_valid && rdy) begin
            if (req_state <= 3'd4) m_q.push_back('{st: int'(req_state), dur: int'(req_duration)});
            else m_inv = 1;
        end
        m_live = 1;
    endtask

    task automatic check_all(input string p);
        chk({p, "sel"},   32'(state_select), 32'(m_sel));
        chk({p, "dur"},   32'(transition_duration), 32'(m_dur));
        chk({p, "busy"},  32'(busy), 32'(ph != 0));
        chk({p, "count"}, 32'(queue_count), 32'(m_q.size()));
        chk({p, "ready"}, 32'(req_ready), 32'(m_ready()));
        chk({p, "inv"},   32'(err_invalid), 32'(m_inv));
        chk({p, "tout"},  32'(err_timeout), 32'(m_to));
    endtask

    task automatic drive();
        int r;
        clk_en    = ($urandom % 2) == 0;
        req_valid = ($urandom % 3) == 0;
        r = $urandom % 16;
        req_state    = (r < 14) ? 3'(r % 5) : 3'(5 + (r % 3));
        req_duration = 16'($urandom);
        flush = ($urandom % 60) == 0;
        if (ph == 0) no_resp = ($urandom % 5) == 0;
        if (ph == 1)      transitioning = !no_resp && (($urandom % 3) == 0);
        else if (ph == 2) transitioning = ($urandom % 5) != 0;
        else              transitioning = 1'b0;
    endtask

    bit did_rst = 0;

    initial begin
        m_reset();
        no_resp = 0;
        #7;
        check_all("rst_");
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            if (rst_n) m_step();
            #1;
            if (!rst_n) rst_n = 1'b1;
            drive();
            if (!did_rst && i > 500 && ph == 2 && m_q.size() >= 2) begin
                // Asynchronous reset in the middle of a transition.
                did_rst = 1;
                clk_en = 0; req_valid = 0; flush = 0; transitioning = 0;
                rst_n = 1'b0;
                m_reset();
                #1;
                check_all("midrst_");
            end
            @(negedge clk);
            check_all("");
        end
        chk("midrst_seen", 32'(did_rst), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
